// File: rtl/video_pkg.sv
// video_pkg: config field addresses, timing record, 640x480 defaults and config helpers
package video_pkg;
  localparam logic [2:0] CFG_H_ACTIVE = 3'd0, CFG_H_FRONT = 3'd1, CFG_H_SYNC = 3'd2, CFG_H_BACK = 3'd3;
  localparam logic [2:0] CFG_V_ACTIVE = 3'd4, CFG_V_FRONT = 3'd5, CFG_V_SYNC = 3'd6, CFG_V_BACK = 3'd7;
  typedef struct packed {
    logic [10:0] h_active;
    logic [10:0] h_front;
    logic [10:0] h_sync;
    logic [10:0] h_back;
    logic [10:0] v_active;
    logic [10:0] v_front;
    logic [10:0] v_sync;
    logic [10:0] v_back;
  } timing_t;
  localparam timing_t TIMING_640X480 = '{
    h_active: 11'd640, h_front: 11'd16, h_sync: 11'd96, h_back: 11'd48,
    v_active: 11'd480, v_front: 11'd10, v_sync: 11'd2, v_back: 11'd33
  };
  function automatic logic [11:0] sum4(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c, input logic [10:0] d);
    return 12'(a) + 12'(b) + 12'(c) + 12'(d);
  endfunction
  function automatic logic cfg_fits(input timing_t t);
    return sum4(t.h_active, t.h_front, t.h_sync, t.h_back) <= 12'd2047 &&
           sum4(t.v_active, t.v_front, t.v_sync, t.v_back) <= 12'd2047;
  endfunction
  function automatic timing_t set_field(input timing_t t, input logic [2:0] addr, input logic [10:0] data);
    timing_t r;
    logic [10:0] v;
    v = data == '0 ? 11'd1 : data;
    r = t;
    r.h_active = addr == CFG_H_ACTIVE ? v : t.h_active;
    r.h_front  = addr == CFG_H_FRONT  ? v : t.h_front;
    r.h_sync   = addr == CFG_H_SYNC   ? v : t.h_sync;
    r.h_back   = addr == CFG_H_BACK   ? v : t.h_back;
    r.v_active = addr == CFG_V_ACTIVE ? v : t.v_active;
    r.v_front  = addr == CFG_V_FRONT  ? v : t.v_front;
    r.v_sync   = addr == CFG_V_SYNC   ? v : t.v_sync;
    r.v_back   = addr == CFG_V_BACK   ? v : t.v_back;
    return r;
  endfunction
endpackage

// File: rtl/video_timing_axis.sv
// video_timing_axis: one timing axis counter with blank/sync decode and wrap/advance handshake
module video_timing_axis (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_run,
  input  logic        i_advance,
  input  logic [10:0] i_active,
  input  logic [10:0] i_front,
  input  logic [10:0] i_sync,
  input  logic [10:0] i_back,
  output logic [10:0] o_count,
  output logic        o_wrap,
  output logic        o_blank,
  output logic        o_sync
);
  logic [11:0] cnt, sync_start, sync_end, total;
  assign cnt        = {1'b0, o_count};
  assign sync_start = 12'(i_active) + 12'(i_front);
  assign sync_end   = sync_start + 12'(i_sync);
  assign total      = sync_end + 12'(i_back);
  assign o_wrap     = i_run && i_advance && cnt == total - 12'd1;
  assign o_blank    = cnt >= 12'(i_active);
  assign o_sync     = cnt >= sync_start && cnt < sync_end;
  // count on each advance, fold to 0 at the end of the period, hold at 0 while stopped
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) o_count <= '0;
    else o_count <= !i_run || o_wrap ? '0 : i_advance ? o_count + 11'd1 : o_count;
endmodule

// File: rtl/video_timing.sv
// video_timing: programmable raster timing generator with frame-synchronous config commit
module video_timing
  import video_pkg::*;
#(
  parameter int H_ACTIVE = int'(TIMING_640X480.h_active),
  parameter int H_FRONT  = int'(TIMING_640X480.h_front),
  parameter int H_SYNC   = int'(TIMING_640X480.h_sync),
  parameter int H_BACK   = int'(TIMING_640X480.h_back),
  parameter int V_ACTIVE = int'(TIMING_640X480.v_active),
  parameter int V_FRONT  = int'(TIMING_640X480.v_front),
  parameter int V_SYNC   = int'(TIMING_640X480.v_sync),
  parameter int V_BACK   = int'(TIMING_640X480.v_back)
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic        i_cfg_wr,
  input  logic [2:0]  i_cfg_addr,
  input  logic [10:0] i_cfg_wdata,
  output logic        o_hblank,
  output logic        o_vblank,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_data_enable,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_frame_start,
  output logic        o_cfg_error
);
  localparam timing_t DEFAULTS = '{
    h_active: 11'(H_ACTIVE), h_front: 11'(H_FRONT), h_sync: 11'(H_SYNC), h_back: 11'(H_BACK),
    v_active: 11'(V_ACTIVE), v_front: 11'(V_FRONT), v_sync: 11'(V_SYNC), v_back: 11'(V_BACK)
  };
  timing_t shadow, shadow_next, live;
  logic pending, commit, accept;
  logic h_wrap, v_wrap, h_blank, v_blank, h_sync, v_sync;
  logic [10:0] h_count, v_count;
  assign shadow_next = i_cfg_wr ? set_field(shadow, i_cfg_addr, i_cfg_wdata) : shadow;
  assign commit      = (pending || i_cfg_wr) && (v_wrap || !i_enable);
  assign accept      = cfg_fits(shadow_next);
  video_timing_axis u_h (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_run(i_enable), .i_advance(1'b1),
    .i_active(live.h_active), .i_front(live.h_front), .i_sync(live.h_sync), .i_back(live.h_back),
    .o_count(h_count), .o_wrap(h_wrap), .o_blank(h_blank), .o_sync(h_sync)
  );
  video_timing_axis u_v (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_run(i_enable), .i_advance(h_wrap),
    .i_active(live.v_active), .i_front(live.v_front), .i_sync(live.v_sync), .i_back(live.v_back),
    .o_count(v_count), .o_wrap(v_wrap), .o_blank(v_blank), .o_sync(v_sync)
  );
  // shadow takes writes; live takes the shadow at frame end or while stopped, unless totals overflow
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      shadow      <= DEFAULTS;
      live        <= DEFAULTS;
      pending     <= 1'b0;
      o_cfg_error <= 1'b0;
    end else begin
      shadow      <= shadow_next;
      live        <= commit && accept ? shadow_next : live;
      pending     <= (pending || i_cfg_wr) && !commit;
      o_cfg_error <= commit && !accept ? 1'b1 : i_cfg_wr ? 1'b0 : o_cfg_error;
    end
  // register the decode of the current counter state; stopped timing reads as blank at (0,0)
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      o_hblank      <= 1'b1;
      o_vblank      <= 1'b1;
      o_hsync       <= 1'b0;
      o_vsync       <= 1'b0;
      o_data_enable <= 1'b0;
      o_frame_start <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
    end else begin
      o_hblank      <= !i_enable || h_blank;
      o_vblank      <= !i_enable || v_blank;
      o_hsync       <= i_enable && h_sync;
      o_vsync       <= i_enable && v_sync;
      o_data_enable <= i_enable && !h_blank && !v_blank;
      o_frame_start <= i_enable && h_count == '0 && v_count == '0;
      o_x           <= i_enable ? h_count : '0;
      o_y           <= i_enable ? v_count : '0;
    end
endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: directed and random stimulus checked against a linear-pixel-index raster model
module tb_video_timing;
  localparam int DEF[8] = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam logic [28:0] RST_VEC = {7'b1100000, 22'd0};
  localparam int LIMIT = 20000;
  logic clk = 1'b0;
  logic rst_n, en, wr, o_hblank, o_vblank, o_hsync, o_vsync, o_data_enable, o_frame_start, o_cfg_error;
  logic [2:0] addr;
  logic [10:0] wdata, o_x, o_y;
  int n_assert = 0, n_fail = 0;
  int live[8], shadow[8];
  logic pending;
  int p;
  logic e_hb, e_vb, e_hs, e_vs, e_de, e_fs, e_err;
  int e_x, e_y;
  int n_hs, n_vs, n_de, hs_first, hs_last, n;

  video_timing dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_cfg_wr(wr), .i_cfg_addr(addr), .i_cfg_wdata(wdata),
    .o_hblank(o_hblank), .o_vblank(o_vblank), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_data_enable(o_data_enable), .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start), .o_cfg_error(o_cfg_error)
  );

  always #5 clk = ~clk;

  function automatic logic [28:0] obs();
    return {o_hblank, o_vblank, o_hsync, o_vsync, o_data_enable, o_frame_start, o_cfg_error, o_x, o_y};
  endfunction

  function automatic logic [28:0] expv();
    return {e_hb, e_vb, e_hs, e_vs, e_de, e_fs, e_err, 11'(e_x), 11'(e_y)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    live = DEF;
    shadow = DEF;
    pending = 1'b0;
    p = 0;
    {e_hb, e_vb, e_hs, e_vs, e_de, e_fs, e_err} = 7'b1100000;
    e_x = 0;
    e_y = 0;
  endtask

  // frame position is a single pixel index; x/y and regions follow from division and range tests
  task automatic model_step(input logic e, input logic w, input int a, input int d);
    int sn[8];
    int ht, vt, hs0, vs0;
    logic fe, cm, bad;
    if (!rst_n) model_reset();
    else begin
      sn = shadow;
      if (w) sn[a] = (d == 0) ? 1 : d;
      ht = live[0] + live[1] + live[2] + live[3];
      vt = live[4] + live[5] + live[6] + live[7];
      hs0 = live[0] + live[1];
      vs0 = live[4] + live[5];
      fe = 1'b0;
      if (e) begin
        e_x = p % ht;
        e_y = p / ht;
        e_hb = e_x >= live[0];
        e_vb = e_y >= live[4];
        e_hs = e_x >= hs0 && e_x < hs0 + live[2];
        e_vs = e_y >= vs0 && e_y < vs0 + live[6];
        e_de = !e_hb && !e_vb;
        e_fs = p == 0;
        fe = p == ht * vt - 1;
        p = fe ? 0 : p + 1;
      end else begin
        {e_hb, e_vb, e_hs, e_vs, e_de, e_fs} = 6'b110000;
        e_x = 0;
        e_y = 0;
        p = 0;
      end
      cm = (pending || w) && (!e || fe);
      bad = (sn[0] + sn[1] + sn[2] + sn[3]) % 4096 > 2047 || (sn[4] + sn[5] + sn[6] + sn[7]) % 4096 > 2047;
      if (cm && bad) e_err = 1'b1;
      else if (w) e_err = 1'b0;
      if (cm && !bad) live = sn;
      pending = (pending || w) && !cm;
      shadow = sn;
    end
  endtask

  task automatic cyc(input logic e, input logic w, input int a, input int d);
    en = e;
    wr = w;
    addr = 3'(a);
    wdata = 11'(d);
    @(posedge clk);
    model_step(e, w, a, d);
    #1;
    chk("cycle", obs(), expv());
    n_hs += int'(o_hsync);
    n_vs += int'(o_vsync);
    n_de += int'(o_data_enable);
    if (o_hsync) begin
      if (hs_first < 0) hs_first = int'(o_x);
      hs_last = int'(o_x);
    end
    wr = 1'b0;
  endtask

  task automatic run(input int k);
    repeat (k) cyc(1'b1, 1'b0, 0, 0);
  endtask

  task automatic to_next_fs(output int k);
    k = 0;
    do begin
      cyc(1'b1, 1'b0, 0, 0);
      k++;
    end while (!o_frame_start && k < LIMIT);
  endtask

  task automatic small_cfg();
    cyc(1'b0, 1'b1, 0, 20);
    cyc(1'b0, 1'b1, 1, 4);
    cyc(1'b0, 1'b1, 2, 6);
    cyc(1'b0, 1'b1, 3, 5);
    cyc(1'b0, 1'b1, 4, 12);
    cyc(1'b0, 1'b1, 5, 2);
    cyc(1'b0, 1'b1, 6, 2);
    cyc(1'b0, 1'b1, 7, 3);
  endtask

  initial begin
    logic re;
    rst_n = 1'b0;
    en = 1'b0;
    wr = 1'b0;
    addr = '0;
    wdata = '0;
    model_reset();
    repeat (3) cyc(1'b0, 1'b0, 0, 0);
    chk("reset_state", obs(), RST_VEC);
    rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 0, 0);
    n_hs = 0; n_de = 0; hs_first = -1; hs_last = -1;
    cyc(1'b1, 1'b0, 0, 0);
    chk("first_fs", {o_frame_start, o_x, o_y}, {1'b1, 22'd0});
    run(799);
    chk("hsync_count", n_hs, 96);
    chk("hsync_first", hs_first, 656);
    chk("hsync_last", hs_last, 751);
    chk("de_line", n_de, 640);
    cyc(1'b1, 1'b0, 0, 0);
    chk("h_period_800", {o_x, o_y}, {11'd0, 11'd1});
    small_cfg();
    cyc(1'b1, 1'b0, 0, 0);
    chk("enable_fs", o_frame_start, 1);
    to_next_fs(n);
    chk("frame_665", n, 665);
    run(300);
    cyc(1'b1, 1'b1, 0, 320);
    to_next_fs(n);
    chk("frame_keeps_old", n + 301, 665);
    n_de = 0;
    to_next_fs(n);
    chk("frame_320", n, 6365);
    chk("de_320", n_de, 3840);
    cyc(1'b1, 1'b1, 0, 20);
    to_next_fs(n);
    chk("frame_restore", n + 1, 6365);
    cyc(1'b1, 1'b1, 0, 2047);
    to_next_fs(n);
    chk("cfg_error_set", o_cfg_error, 1);
    chk("frame_before_err", n + 1, 665);
    to_next_fs(n);
    chk("timing_kept", n, 665);
    cyc(1'b1, 1'b1, 0, 20);
    chk("cfg_error_clear", o_cfg_error, 0);
    to_next_fs(n);
    chk("frame_after_clear", n + 1, 665);
    cyc(1'b1, 1'b1, 6, 0);
    to_next_fs(n);
    n_vs = 0;
    to_next_fs(n);
    chk("frame_vsync1", n, 630);
    chk("vsync_1line", n_vs, 35);
    run(280);
    chk("at_y8", {o_x, o_y}, {11'd0, 11'd8});
    repeat (10) begin
      cyc(1'b0, 1'b0, 0, 0);
      chk("gap_blank", {o_hblank, o_vblank, o_data_enable}, 3'b110);
    end
    cyc(1'b1, 1'b0, 0, 0);
    chk("restart_fs", {o_frame_start, o_x, o_y}, {1'b1, 22'd0});
    run(185);
    chk("at_10_5", {o_x, o_y}, {11'd10, 11'd5});
    cyc(1'b1, 1'b1, 1, 9);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", obs(), RST_VEC);
    model_reset();
    repeat (2) cyc(1'b1, 1'b0, 0, 0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 0, 0);
    chk("fs_after_reset", {o_frame_start, o_x, o_y}, {1'b1, 22'd0});
    run(800);
    chk("default_after_reset", {o_x, o_y}, {11'd0, 11'd1});
    repeat (2) cyc(1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 0, 0);
    run(800);
    chk("pending_discarded", {o_x, o_y}, {11'd0, 11'd1});
    small_cfg();
    re = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      int r, a, d;
      logic w;
      re = re ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 3) == 0);
      w = $urandom_range(0, 59) == 0;
      a = int'($urandom_range(0, 7));
      r = int'($urandom_range(0, 15));
      d = r == 0 ? 0 : (r == 1 && (a == 0 || a == 4)) ? 2047 : int'($urandom_range(1, 24));
      cyc(re, w, a, d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
